// File: rtl/alul_arbiter.sv
// alul_arbiter: two-requester bitwise ALU with a single registered result slot.
// Requesters are arbitrated round-robin in IDLE; the accepted operation's
// result is held in RESP until the consumer takes it.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   req0_valid/ready/a/b/sel     requester 0 handshake, operands and opcode
//   req1_valid/ready/a/b/sel     requester 1 handshake, operands and opcode
//   rsp_valid/ready              result handshake
//   rsp_out                      result data
//   rsp_id                       requester index that issued the held result
//   op_count                     completed responses, wraps at 256
module alul_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_id,
  output logic [7:0]       op_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   accept0;
  logic   accept1;

  // Bitwise operation selected by the two-bit opcode.
  function automatic logic [WIDTH-1:0] alu_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       sel
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Round-robin grant: on contention the requester that did not win last time
  // gets the slot; last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready only while idle and out of reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
  end

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;

  // State, result slot and completion counter; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_out    <= '0;
      rsp_id     <= 1'b0;
      op_count   <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            rsp_out    <= alu_op(req0_a, req0_b, req0_sel);
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (accept1) begin
            rsp_out    <= alu_op(req1_a, req1_b, req1_sel);
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= 8'(op_count + 8'd1);
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alul_arbiter.sv
module tb_alul_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [1:0] req0_sel;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [1:0] req1_sel;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_id;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  alul_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_id     (rsp_id),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete operation from requester id, consumer always ready.
  task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] s, input logic [7:0] exp);
    logic rdy;
    rsp_ready = 1'b1;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1'b1;
    end
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      @(negedge clk);
    end
    check("op_ready", rdy, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("op_rsp_valid", rsp_valid, 1'b1);
    check("op_rsp_out", rsp_out, exp);
    check("op_rsp_id", rsp_id, id[0]);
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clk);
    check("op_done_valid", rsp_valid, 1'b0);
    check("op_count", op_count, exp_cnt);
  endtask

  initial begin
    logic [7:0] exp_c;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_sel = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_sel = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_out", rsp_out, 8'h00);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_op_count", op_count, 8'h00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single op and all opcodes.
    do_op(0, 8'hF0, 8'h3C, 2'b00, 8'h30);
    do_op(1, 8'hA5, 8'h0F, 2'b00, 8'h05);
    do_op(1, 8'hA5, 8'h0F, 2'b01, 8'hAF);
    do_op(1, 8'hA5, 8'h0F, 2'b10, 8'hAA);
    do_op(1, 8'hA5, 8'h0F, 2'b11, 8'h5A);

    // Reset while a result is held and the consumer is ready.
    req0_a = 8'h55; req0_b = 8'h0F; req0_sel = 2'b10; req0_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_rsp_valid", rsp_valid, 1'b1);
    check("mid_rsp_out", rsp_out, 8'h5A);
    check("mid_count", op_count, 8'd5);
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_valid", rsp_valid, 1'b0);
    check("rstmid_count", op_count, 8'd0);
    req0_a = 8'h12; req0_b = 8'h34; req0_sel = 2'b01; req0_valid = 1'b1;
    req1_a = 8'h0F; req1_b = 8'hFF; req1_sel = 2'b11; req1_valid = 1'b1;
    #1;
    check("rsthold_ready0", req0_ready, 1'b0);
    check("rsthold_ready1", req1_ready, 1'b0);
    rst = 1'b0;
    exp_cnt = 0;

    // Contention: alternating grants, one response every two cycles.
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_ready0", req0_ready, (k % 2) == 0);
      check("cont_ready1", req1_ready, (k % 2) == 1);
      @(posedge clk);
      @(negedge clk);
      check("cont_valid", rsp_valid, 1'b1);
      check("cont_id", rsp_id, (k % 2) == 1);
      exp_c = ((k % 2) == 0) ? 8'h36 : 8'hF0;
      check("cont_out", rsp_out, exp_c);
      check("cont_busy_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      check("cont_count", op_count, exp_cnt);
    end

    // Backpressure: both still requesting, consumer stalls five cycles.
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_out", rsp_out, 8'h36);
      check("bp_hold_id", rsp_id, 1'b0);
      check("bp_hold_ready", {req0_ready, req1_ready}, 2'b00);
      check("bp_hold_count", op_count, exp_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    check("bp_count", op_count, exp_cnt);
    check("bp_done_valid", rsp_valid, 1'b0);
    check("bp_next_ready1", req1_ready, 1'b1);
    check("bp_next_ready0", req0_ready, 1'b0);

    // Withdrawal and idle rsp_ready have no side effect.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_valid", rsp_valid, 1'b0);
    check("idle_count", op_count, exp_cnt);
    check("idle_out", rsp_out, 8'h36);

    // Counter wrap: 256 back-to-back ops from requester 0.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req0_a = 8'hFF; req0_b = 8'h01; req0_sel = 2'b00; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (510) @(posedge clk);
    @(negedge clk);
    check("wrap_255", op_count, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrap_0", op_count, 8'h00);
    check("wrap_out", rsp_out, 8'h01);
    req0_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alul_arbiter.md
ALUL_ARBITER -- requirements
Module: alul_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a / req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_sel  input  2  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same directions and widths as requester 0, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_out  output  WIDTH  result.
REQ-012 rsp_id  output  1  index of the requester that issued the result.
REQ-013 op_count  output  8  count of completed responses.

Function
REQ-014 The block SHALL implement a two-state FSM:
- IDLE: no result held.
- RESP: result held, rsp_valid=1.
REQ-015 Grant in IDLE SHALL be computed combinationally:
- Only one valid requester: grant it.
- Both valid: grant the requester not recorded in last_grant.
- Neither valid: no grant.
REQ-016 reqN_ready SHALL be 1 only when state=IDLE and requester N is granted; it SHALL be 0 in RESP.
REQ-017 An accept is reqN_valid & reqN_ready at a clock edge. On an accept the block SHALL, at that edge:
- register the result;
- set rsp_id=N;
- set last_grant=N;
- enter RESP.
REQ-018 The result SHALL be computed from the accepted operands:
- sel 00: A AND B
- sel 01: A OR B
- sel 10: A XOR B
- sel 11: NOT A (B ignored)
All operations are bitwise over WIDTH bits.
REQ-019 Latency: accept at edge T gives rsp_valid=1 from cycle T+1.
REQ-020 In RESP, rsp_out, rsp_id and rsp_valid SHALL hold stable until rsp_valid & rsp_ready at an edge. At that edge the block SHALL:
- return to IDLE;
- increment op_count.
REQ-021 op_count SHALL wrap from 255 to 0.
REQ-022 Throughput: at most one accept per 2 cycles. There is no accept in the cycle a response completes; the next accept can occur one cycle later.
REQ-023 A requester not granted SHALL see ready=0. A held request SHALL remain pending with no loss. Requesters are required to hold operands and sel stable while valid & !ready.
REQ-024 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-025 Deasserting valid before it is granted SHALL withdraw the request without any side effect.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set:
- state=IDLE
- rsp_valid=0
- rsp_out=0
- rsp_id=0
- op_count=0
- last_grant=1, so requester 0 wins the first contention.
REQ-027 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-028 Reset in RESP SHALL discard the held result without incrementing op_count.
REQ-029 Reset SHALL take priority over any simultaneous accept or response handshake.

Verification
REQ-030 Single op: req0 valid, A=0xF0, B=0x3C, sel=00, rsp_ready=1 -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_out=0x30, rsp_id=0; op_count=1 after the handshake.
REQ-031 All opcodes: A=0xA5, B=0x0F on sel 00/01/10/11 -> rsp_out=0x05/0xAF/0xAA/0x5A in turn.
REQ-032 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one response every 2 cycles.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles after a result:
- rsp_out and rsp_id stay stable;
- both ready=0 throughout;
- on rsp_ready=1, one handshake occurs and op_count increments by exactly 1.
REQ-034 Wrap: 256 completed ops -> op_count returns to 0x00.
REQ-035 Reset mid-RESP: rst=1 while rsp_valid=1 and rsp_ready=1 -> next cycle rsp_valid=0, op_count=0; the next contention grants requester 0.
